pipelined_arithmetic_logic_unit: RTL and testbench
==================================================

# pipelined_arithmetic_logic_unit

Parametrised successor to the datapath ALU, with valid/ready handshakes on both sides and a registered result. It keeps the existing 16-operation set in full-width and half-width modes, plus the registered {Z,C,N,O} flags with a write enable. It adds an iterative shift-and-add multiplier (MUL/MULH). It sits between operand muxes and register write-back in the next-generation datapath.

## Interface
- WIDTH, 16, operand/result width; even, ≥ 8. H = WIDTH/2.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- A, B  in  WIDTH  operands.
- FunSel  in  6  operation select:
  - [5]=1 selects extended ops.
  - [4]=1 selects full width; [4]=0 selects half width (low H bits).
  - [3:0] is the opcode.
- WF  in  1  write flags for this operation.
- InValid  in  1  operation offered.
- InReady  out  1  operation accepted when InValid&&InReady at an edge.
- ALUOut  out  WIDTH  registered result.
- OutValid  out  1  ALUOut holds an unconsumed result.
- OutReady  in  1  consumer takes the result when OutValid&&OutReady.
- FlagsOut  out  4  registered flags {Z,C,N,O}.
- Busy  out  1  multiply in progress.

## Operation
- Base opcodes ([5]=0):
  - 0 A; 1 B; 2 ~A; 3 ~B.
  - 4 A+B; 5 A+B+C; 6 A−B.
  - 7 AND; 8 OR; 9 XOR; A NAND.
  - B LSL A; C LSR A; D ASR A; E rotate-left A; F rotate-right A.
  - Rotates do not pass through C.
- Extended opcodes ([5]=1):
  - 0 MUL: low half of the unsigned product.
  - 1 MULH: high half of the unsigned product.
  - 2–F reserved: result = A, flags unchanged.
- Operating width n = WIDTH when [4]=1, H when [4]=0. In half width, ALUOut[WIDTH-1:H] = 0.
- Flag rules:
  - All ops: Z = (n-bit result == 0); N = result bit n−1.
  - C for add/ADC: carry-out.
  - C for sub: borrow, i.e. 1 iff A <u B (n bits).
  - C for LSL/LSR/rotates: the shifted-out bit. ASR leaves C unchanged.
  - O: signed overflow for add/ADC/sub only; otherwise unchanged.
  - MUL: C = (high half ≠ 0). MULH: C = 0. O unchanged for both.
- Flags are written only when WF is set. WF is sampled at acceptance.
- ADC uses the FlagsOut C value at the accepting edge.
- FSM states:
  - IDLE: ready for a new operation.
  - MUL: n iterations, one bit per cycle. Operands, op, width and WF are latched at acceptance; the counter loads n.
  - The final MUL cycle loads ALUOut and flags, sets OutValid and returns to IDLE.
- InReady = (state==IDLE) && (!OutValid || OutReady).
- Holding a result: while OutValid && !OutReady, ALUOut and FlagsOut are held stable and nothing is accepted.
- Consume and accept on the same edge: the new result replaces the old one; OutValid stays 1.
- Reset (any time, including mid-MUL):
  - ALUOut=0, OutValid=0, FlagsOut=0000, Busy=0, state=IDLE.
  - The in-progress multiply is discarded.
  - InReady=1 from the first edge after release.

## Timing
- Non-multiply ops: combinational on A/B/FunSel/flags; ALUOut and FlagsOut load at the accepting edge. Latency 1; throughput 1 per cycle.
- Back-to-back ADC sees the C value written by the previous operation.
- MUL/MULH: result at edge n+1 after acceptance. Busy=1 for those n cycles; InReady=0 throughout.
- The multiplier's WF write happens only at completion. Flags are never altered mid-iteration.

## Structure
- Package alu_pkg holds:
  - the opcode localparams;
  - the FSM state enum {IDLE, MUL};
  - the flag bit indices Z=3, C=2, N=1, O=0.
- Sub-module alu_shift_add_multiplier (parameter WIDTH):
  - ports: start, half, a, b, done, product[WIDTH*2-1:0];
  - contains the iteration counter and partial-product register;
  - the top level selects low or high half.
- Base-op combinational datapath and flag logic live in the top level.

## Test plan
- Reset: assert Reset=0 during a MUL at iteration 5 → ALUOut=0000, FlagsOut=0000, OutValid=0, Busy=0. InReady=1 the cycle after release; no stale result appears.
- Add then ADC chain:
  - FunSel=010100, A=1234, B=4321, WF=1 → next edge ALUOut=5555, FlagsOut=0000.
  - FunSel=010101, A=7777, B=8889, C=0 → 0000, Z=1 C=1 N=0 O=0.
  - Next ADC with A=0, B=0 → 0001, flags 0000.
- Half-width sub/shift:
  - FunSel=000110, A=0077, B=0089 → 00EE, Z0 C1 N1 O1.
  - FunSel=001011, A=00BC, flags preset 1010 → 0078, C=1, O=0.
- Multiply (WIDTH=16):
  - FunSel=110000, A=00FF, B=0101 → 17 edges later ALUOut=FFFF, C=0, Busy high for 16 cycles.
  - FunSel=110001, A=FFFF, B=FFFF → FFFE.
  - FunSel=110000, same operands → 0001, C=1.
- Backpressure:
  - OutReady=0 with OutValid=1 → InReady=0; InValid pulses are ignored; ALUOut and FlagsOut are stable for 10 cycles.
  - Raising OutReady with a new op on the same edge → new result, no bubble.
- WF=0: FunSel=010110, A=FFFF, B=FFFF with flags preset 1111 → ALUOut=0000, FlagsOut stays 1111.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM state and flag indices for the pipelined ALU
package alu_pkg;

   localparam logic [3:0] OP_PASS_A = 4'h0;
   localparam logic [3:0] OP_PASS_B = 4'h1;
   localparam logic [3:0] OP_NOT_A  = 4'h2;
   localparam logic [3:0] OP_NOT_B  = 4'h3;
   localparam logic [3:0] OP_ADD    = 4'h4;
   localparam logic [3:0] OP_ADC    = 4'h5;
   localparam logic [3:0] OP_SUB    = 4'h6;
   localparam logic [3:0] OP_AND    = 4'h7;
   localparam logic [3:0] OP_OR     = 4'h8;
   localparam logic [3:0] OP_XOR    = 4'h9;
   localparam logic [3:0] OP_NAND   = 4'hA;
   localparam logic [3:0] OP_LSL    = 4'hB;
   localparam logic [3:0] OP_LSR    = 4'hC;
   localparam logic [3:0] OP_ASR    = 4'hD;
   localparam logic [3:0] OP_ROL    = 4'hE;
   localparam logic [3:0] OP_ROR    = 4'hF;

   localparam logic [3:0] OP_MUL    = 4'h0;
   localparam logic [3:0] OP_MULH   = 4'h1;

   typedef enum logic {IDLE, MUL} alu_state_e;

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

endpackage

// File: rtl/alu_shift_add_multiplier.sv
// rtl/alu_shift_add_multiplier.sv - iterative unsigned multiplier, one multiplier bit per cycle
module alu_shift_add_multiplier #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 half,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [WIDTH*2-1:0]   product
);

   localparam int H  = WIDTH / 2;
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH*2-1:0] acc_q;
   logic [WIDTH*2-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CW-1:0]      cnt_q;
   logic               run_q;
   logic [WIDTH-1:0]   a_n;
   logic [WIDTH-1:0]   b_n;

   assign a_n = half ? {{(WIDTH-H){1'b0}}, a[H-1:0]} : a;
   assign b_n = half ? {{(WIDTH-H){1'b0}}, b[H-1:0]} : b;

   // run_q stays set through the cycle where cnt_q reaches zero so done lasts exactly one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else if (start) begin
         acc_q    <= '0;
         mcand_q  <= {{WIDTH{1'b0}}, a_n};
         mplier_q <= b_n;
         cnt_q    <= half ? CW'(H) : CW'(WIDTH);
         run_q    <= 1'b1;
      end else if (run_q) begin
         if (cnt_q != '0) begin
            if (mplier_q[0]) begin
               acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
         end else begin
            run_q <= 1'b0;
         end
      end
   end

   assign done    = run_q && (cnt_q == '0);
   assign product = acc_q;

endmodule

// File: rtl/pipelined_arithmetic_logic_unit.sv
// rtl/pipelined_arithmetic_logic_unit.sv - handshaked ALU with registered result/flags and iterative multiply
module pipelined_arithmetic_logic_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [5:0]       FunSel,
   input  logic             WF,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] ALUOut,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [3:0]       FlagsOut,
   output logic             Busy
);

   localparam int H = WIDTH / 2;

   alu_state_e         state_q;
   logic [WIDTH-1:0]   alu_out_q;
   logic [3:0]         flags_q;
   logic               out_valid_q;
   logic               mul_hi_q, mul_half_q, mul_wf_q;

   logic               half, ext, is_mul, accept, mul_done;
   logic [WIDTH-1:0]   mask, top_bit, a_n, b_n, base_res, mul_res, prod_lo, prod_hi;
   logic [WIDTH:0]     sum, diff;
   logic [3:0]         base_flags, mul_flags;
   logic [WIDTH*2-1:0] product;

   function automatic logic msb(input logic [WIDTH-1:0] x, input logic hf);
      return hf ? x[H-1] : x[WIDTH-1];
   endfunction

   assign half    = ~FunSel[4];
   assign ext     = FunSel[5];
   assign is_mul  = ext && (FunSel[3:0] == OP_MUL || FunSel[3:0] == OP_MULH);
   assign mask    = half ? {{(WIDTH-H){1'b0}}, {H{1'b1}}} : {WIDTH{1'b1}};
   assign top_bit = mask ^ (mask >> 1);
   assign a_n     = A & mask;
   assign b_n     = B & mask;
   assign sum     = {1'b0, a_n} + {1'b0, b_n}
                  + {{WIDTH{1'b0}}, (FunSel[3:0] == OP_ADC) & flags_q[FLAG_C]};
   // operands are zero-extended, so the top bit of the difference is the borrow in either width
   assign diff    = {1'b0, a_n} - {1'b0, b_n};

   always_comb begin
      base_res   = a_n;
      base_flags = flags_q;
      case (FunSel[3:0])
         OP_PASS_A: base_res = a_n;
         OP_PASS_B: base_res = b_n;
         OP_NOT_A:  base_res = ~a_n;
         OP_NOT_B:  base_res = ~b_n;
         OP_ADD, OP_ADC: begin
            base_res = sum[WIDTH-1:0] & mask;
            base_flags[FLAG_C] = half ? sum[H] : sum[WIDTH];
            base_flags[FLAG_O] = (msb(a_n, half) == msb(b_n, half)) &&
                                 (msb(base_res, half) != msb(a_n, half));
         end
         OP_SUB: begin
            base_res = diff[WIDTH-1:0] & mask;
            base_flags[FLAG_C] = diff[WIDTH];
            base_flags[FLAG_O] = (msb(a_n, half) != msb(b_n, half)) &&
                                 (msb(base_res, half) != msb(a_n, half));
         end
         OP_AND:  base_res = a_n & b_n;
         OP_OR:   base_res = a_n | b_n;
         OP_XOR:  base_res = a_n ^ b_n;
         OP_NAND: base_res = ~(a_n & b_n);
         OP_LSL: begin
            base_res = a_n << 1;
            base_flags[FLAG_C] = msb(a_n, half);
         end
         OP_LSR: begin
            base_res = a_n >> 1;
            base_flags[FLAG_C] = a_n[0];
         end
         OP_ASR:  base_res = (a_n >> 1) | (msb(a_n, half) ? top_bit : '0);
         OP_ROL: begin
            base_res = (a_n << 1) | {{(WIDTH-1){1'b0}}, msb(a_n, half)};
            base_flags[FLAG_C] = msb(a_n, half);
         end
         OP_ROR: begin
            base_res = (a_n >> 1) | (a_n[0] ? top_bit : '0);
            base_flags[FLAG_C] = a_n[0];
         end
         default: base_res = a_n;
      endcase
      base_res = base_res & mask;
      base_flags[FLAG_Z] = (base_res == '0);
      base_flags[FLAG_N] = msb(base_res, half);
   end

   alu_shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
      .clk     (Clock),
      .rst_n   (Reset),
      .start   (accept && is_mul),
      .half    (half),
      .a       (A),
      .b       (B),
      .done    (mul_done),
      .product (product)
   );

   assign prod_lo = mul_half_q ? {{(WIDTH-H){1'b0}}, product[H-1:0]} : product[WIDTH-1:0];
   assign prod_hi = mul_half_q ? {{(WIDTH-H){1'b0}}, product[WIDTH-1:H]} : product[WIDTH*2-1:WIDTH];
   assign mul_res = mul_hi_q ? prod_hi : prod_lo;

   always_comb begin
      mul_flags         = flags_q;
      mul_flags[FLAG_Z] = (mul_res == '0);
      mul_flags[FLAG_C] = mul_hi_q ? 1'b0 : (prod_hi != '0);
      mul_flags[FLAG_N] = msb(mul_res, mul_half_q);
   end

   assign InReady  = (state_q == IDLE) && (!out_valid_q || OutReady);
   assign accept   = InValid && InReady;
   assign Busy     = (state_q == MUL) && !mul_done;
   assign ALUOut   = alu_out_q;
   assign OutValid = out_valid_q;
   assign FlagsOut = flags_q;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q     <= IDLE;
         alu_out_q   <= '0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
         mul_hi_q    <= 1'b0;
         mul_half_q  <= 1'b0;
         mul_wf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (is_mul) begin
                     state_q     <= MUL;
                     mul_hi_q    <= (FunSel[3:0] == OP_MULH);
                     mul_half_q  <= half;
                     mul_wf_q    <= WF;
                     out_valid_q <= 1'b0;
                  end else if (ext) begin
                     alu_out_q   <= a_n;
                     out_valid_q <= 1'b1;
                  end else begin
                     alu_out_q   <= base_res;
                     if (WF) flags_q <= base_flags;
                     out_valid_q <= 1'b1;
                  end
               end else if (OutReady) begin
                  out_valid_q <= 1'b0;
               end
            end
            MUL: begin
               if (mul_done) begin
                  alu_out_q   <= mul_res;
                  if (mul_wf_q) flags_q <= mul_flags;
                  out_valid_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pipelined_arithmetic_logic_unit.sv
// tb/tb_pipelined_arithmetic_logic_unit.sv - scoreboard bench with an arithmetic reference model
module tb_pipelined_arithmetic_logic_unit;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [15:0] A = '0, B = '0;
   logic [5:0]  FunSel = '0;
   logic        WF = 1'b0, InValid = 1'b0, OutReady = 1'b0;
   logic        InReady, OutValid, Busy;
   logic [15:0] ALUOut;
   logic [3:0]  FlagsOut;

   typedef struct packed {
      logic [15:0] res;
      logic [3:0]  fl;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0, n_bad = 0;
   logic [3:0] mflags = 4'h0;
   bit   rand_ready = 0;

   pipelined_arithmetic_logic_unit #(.WIDTH(16)) dut (
      .Clock(Clock), .Reset(Reset), .A(A), .B(B), .FunSel(FunSel), .WF(WF),
      .InValid(InValid), .InReady(InReady), .ALUOut(ALUOut), .OutValid(OutValid),
      .OutReady(OutReady), .FlagsOut(FlagsOut), .Busy(Busy)
   );

   initial forever #5 Clock = ~Clock;

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: n-bit unsigned/signed arithmetic on integers; mflags is the flag state after the last issued op
   function automatic exp_t model(input logic [5:0] fs, input logic [15:0] a, input logic [15:0] b,
                                  input logic wf);
      longint lim, hl, av, bv, sa, sb, r, s, p, hi, cin;
      logic [3:0] f;
      exp_t e;
      lim = longint'(1) << (fs[4] ? 16 : 8);
      hl  = lim / 2;
      av  = longint'(a) % lim;
      bv  = longint'(b) % lim;
      sa  = (av >= hl) ? av - lim : av;
      sb  = (bv >= hl) ? bv - lim : bv;
      cin = (fs[3:0] == 4'd5) ? longint'(mflags[2]) : 0;
      f   = mflags;
      r   = av;
      if (fs[5]) begin
         if (fs[3:0] <= 4'd1) begin
            p  = av * bv;
            hi = p / lim;
            r  = fs[0] ? hi : p % lim;
            f[2] = fs[0] ? 1'b0 : (hi != 0);
         end
      end else begin
         case (fs[3:0])
            4'd0: r = av;
            4'd1: r = bv;
            4'd2: r = lim - 1 - av;
            4'd3: r = lim - 1 - bv;
            4'd4, 4'd5: begin
               s = av + bv + cin;  r = s % lim;  f[2] = (s >= lim);
               s = sa + sb + cin;  f[0] = (s < -hl) || (s >= hl);
            end
            4'd6: begin
               r = (av - bv + lim) % lim;  f[2] = (av < bv);
               s = sa - sb;  f[0] = (s < -hl) || (s >= hl);
            end
            4'd7:  r = av & bv;
            4'd8:  r = av | bv;
            4'd9:  r = av ^ bv;
            4'd10: r = (lim - 1) - (av & bv);
            4'd11: begin r = (av * 2) % lim;  f[2] = (av >= hl); end
            4'd12: begin r = av / 2;  f[2] = ((av % 2) != 0); end
            4'd13: r = av / 2 + ((av >= hl) ? hl : 0);
            4'd14: begin r = (av * 2) % lim + ((av >= hl) ? 1 : 0);  f[2] = (av >= hl); end
            default: begin r = av / 2 + (av % 2) * hl;  f[2] = ((av % 2) != 0); end
         endcase
      end
      if (!(fs[5] && fs[3:0] > 4'd1)) begin
         f[3] = (r == 0);
         f[1] = (r >= hl);
      end
      if (wf) mflags = f;
      e.res = r[15:0];
      e.fl  = mflags;
      return e;
   endfunction

   task automatic issue(input logic [5:0] fs, input logic [15:0] a, input logic [15:0] b, input logic wf);
      int t = 0;
      FunSel = fs;  A = a;  B = b;  WF = wf;  InValid = 1'b1;
      while (1) begin
         @(negedge Clock);
         if (InReady) break;
         t++;
         if (t > 300) begin
            check("issue_timeout", t, 0);
            InValid = 1'b0;
            return;
         end
         @(posedge Clock); #1;
         if (rand_ready) OutReady = ($urandom % 3) != 0;
      end
      @(posedge Clock);
      sb_q.push_back(model(fs, a, b, wf));
      #1 InValid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb_q.size() != 0 && t < 200) begin
         @(posedge Clock); #1;
         t++;
      end
      check("drain", sb_q.size(), 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge Clock);
         if (Reset && OutValid && OutReady) begin
            if (sb_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = sb_q.pop_front();
               check("result", ALUOut, e.res);
               check("flags", FlagsOut, e.fl);
            end
         end
      end
   end

   initial begin : stim
      int k, busy_n, irdy_n, stale;
      exp_t held;
      logic [15:0] ra, rb;

      repeat (3) @(posedge Clock);
      #1;
      check("reset_aluout", ALUOut, 0);
      check("reset_flags", FlagsOut, 0);
      check("reset_outvalid", OutValid, 0);
      check("reset_busy", Busy, 0);
      Reset = 1'b1;
      OutReady = 1'b1;
      @(negedge Clock);
      check("inready_after_reset", InReady, 1);
      @(posedge Clock); #1;

      issue(6'b010100, 16'h1234, 16'h4321, 1'b1);
      issue(6'b010101, 16'h7777, 16'h8889, 1'b1);
      issue(6'b010101, 16'h0000, 16'h0000, 1'b1);
      issue(6'b000110, 16'h0077, 16'h0089, 1'b1);
      issue(6'b001011, 16'h00BC, 16'h0000, 1'b1);
      issue(6'b010110, 16'hFFFF, 16'hFFFF, 1'b0);
      drain();

      issue(6'b110000, 16'h00FF, 16'h0101, 1'b1);
      busy_n = Busy;
      irdy_n = InReady;
      k = 0;
      while (!OutValid && k < 40) begin
         @(posedge Clock); #1;
         k++;
         if (!OutValid) begin
            busy_n += Busy;
            irdy_n += InReady;
         end
      end
      check("mul_latency", k, 17);
      check("mul_busy_cycles", busy_n, 16);
      check("mul_inready_high", irdy_n, 0);
      issue(6'b110001, 16'hFFFF, 16'hFFFF, 1'b1);
      issue(6'b110000, 16'hFFFF, 16'hFFFF, 1'b1);
      issue(6'b100001, 16'h1234, 16'h0056, 1'b1);
      drain();

      OutReady = 1'b0;
      issue(6'b010100, 16'h8000, 16'h8000, 1'b1);
      held = sb_q[0];
      for (int i = 0; i < 10; i++) begin
         InValid = 1'b1;  FunSel = 6'b010001;  A = 16'(i);  B = 16'hA5A5;  WF = 1'b1;
         @(negedge Clock);
         check("hold_inready", InReady, 0);
         check("hold_aluout", ALUOut, held.res);
         check("hold_flags", FlagsOut, held.fl);
         @(posedge Clock); #1;
         InValid = 1'b0;
      end
      OutReady = 1'b1;
      issue(6'b010100, 16'h0003, 16'h0004, 1'b1);
      check("no_bubble", OutValid, 1);
      drain();

      issue(6'b110000, 16'($urandom), 16'($urandom), 1'b1);
      repeat (5) @(posedge Clock);
      #1 Reset = 1'b0;
      sb_q.delete();
      mflags = 4'h0;
      #1;
      check("midmul_reset_aluout", ALUOut, 0);
      check("midmul_reset_flags", FlagsOut, 0);
      check("midmul_reset_outvalid", OutValid, 0);
      check("midmul_reset_busy", Busy, 0);
      @(posedge Clock); #1 Reset = 1'b1;
      @(negedge Clock);
      check("inready_after_midmul_reset", InReady, 1);
      stale = 0;
      repeat (25) begin
         @(negedge Clock);
         if (OutValid || Busy) stale++;
      end
      check("no_stale_result", stale, 0);
      @(posedge Clock); #1;

      rand_ready = 1;
      for (int i = 0; i < 300; i++) begin
         case ($urandom % 4)
            0:       ra = 16'h0000;
            1:       ra = 16'hFFFF;
            default: ra = 16'($urandom);
         endcase
         rb = ($urandom % 5 == 0) ? ra : 16'($urandom);
         issue(6'($urandom), ra, rb, 1'($urandom));
         repeat ($urandom % 3) begin
            @(posedge Clock); #1;
            OutReady = ($urandom % 3) != 0;
         end
      end
      rand_ready = 0;
      OutReady = 1'b1;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
